washer_task_sequencer: RTL and testbench

- Top-level task controller for the washer-response path.
- On a washer detection it arms the frequency detector (freq_enable) and waits for done_count, then decodes the returned 3-bit command (one-hot: 001 Turn180, 010 StoreWasher, 100 GoToSound).
- Launches the matching motion task with a one-cycle start pulse and supervises it with timeouts and bounded retries.
- Sits between the washer sensor, the frequency module and the drive/claw/sound-seek tasks.

---
 rtl/washer_pkg.sv | 26 ++
 rtl/cycle_timer.sv | 42 ++++
 rtl/washer_task_sequencer.sv | 175 +++++++++++++++++
 tb/tb_washer_task_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/washer_pkg.sv
// ---------------------------------------------------------------------------
// washer_pkg : sequencer states and frequency-module command codes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package washer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LISTEN   = 3'd1,
        DECODE   = 3'd2,
        REARM    = 3'd3,
        TURN     = 3'd4,
        STORE    = 3'd5,
        SEEK     = 3'd6,
        COOLDOWN = 3'd7
    } state_e;

    localparam logic [2:0] CMD_NONE      = 3'b000;
    localparam logic [2:0] CMD_TURN180   = 3'b001;
    localparam logic [2:0] CMD_STORE     = 3'b010;
    localparam logic [2:0] CMD_GOTOSOUND = 3'b100;

endpackage

`default_nettype wire

// File: rtl/cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer : loadable saturating down-counter with expiry flag. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cycle_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the cycle whose decrement reaches zero, so a load of N spans N cycles.
    assign zero_o = (count_q <= CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/washer_task_sequencer.sv
// ---------------------------------------------------------------------------
// washer_task_sequencer : listen/decode/launch/supervise washer tasks. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module washer_task_sequencer
    import washer_pkg::*;
#(
    parameter int unsigned LISTEN_TIMEOUT  = 300_000_000,
    parameter int unsigned ACT_TIMEOUT     = 500_000_000,
    parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
    parameter int unsigned MAX_RETRIES     = 3,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       washer_detected,
    input  logic       done_count,
    input  logic [2:0] command,
    input  logic       turn_done,
    input  logic       store_done,
    input  logic       seek_done,
    output logic       freq_enable,
    output logic       turn_start,
    output logic       store_start,
    output logic       seek_start,
    output logic       busy,
    output logic       fault,
    output logic [2:0] last_cmd
);

    localparam int unsigned RET_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    state_e           state_q, state_d;
    logic [RET_W-1:0] retries_q, retries_d;
    logic             fault_q, fault_d;
    logic [2:0]       last_cmd_q, last_cmd_d;
    logic             turn_start_q, turn_start_d;
    logic             store_start_q, store_start_d;
    logic             seek_start_q, seek_start_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic             tmr_zero;

    cycle_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d       = state_q;
        retries_d     = retries_q;
        fault_d       = fault_q;
        last_cmd_d    = last_cmd_q;
        turn_start_d  = 1'b0;
        store_start_d = 1'b0;
        seek_start_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (washer_detected) begin
                    state_d   = LISTEN;
                    fault_d   = 1'b0;
                    retries_d = '0;
                end
            end
            LISTEN: begin
                if (done_count) begin
                    state_d = DECODE;
                end else if (tmr_zero) begin
                    state_d = REARM;
                end
            end
            DECODE: begin
                case (command)
                    CMD_TURN180: begin
                        state_d      = TURN;
                        turn_start_d = 1'b1;
                        last_cmd_d   = command;
                    end
                    CMD_STORE: begin
                        state_d       = STORE;
                        store_start_d = 1'b1;
                        last_cmd_d    = command;
                    end
                    CMD_GOTOSOUND: begin
                        state_d      = SEEK;
                        seek_start_d = 1'b1;
                        last_cmd_d   = command;
                    end
                    default: state_d = REARM;
                endcase
            end
            REARM: begin
                retries_d = retries_q + RET_W'(1);
                if (retries_d == RET_W'(MAX_RETRIES)) begin
                    state_d = COOLDOWN;
                    fault_d = 1'b1;
                end else begin
                    state_d = LISTEN;
                end
            end
            TURN, STORE, SEEK: begin
                // Only the launched task's done counts; it wins over a coincident timeout.
                if (((state_q == TURN)  && turn_done)  ||
                    ((state_q == STORE) && store_done) ||
                    ((state_q == SEEK)  && seek_done)) begin
                    state_d = COOLDOWN;
                end else if (tmr_zero) begin
                    state_d = COOLDOWN;
                    fault_d = 1'b1;
                end
            end
            COOLDOWN: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_load_val = '0;
        case (state_d)
            LISTEN:            tmr_load_val = CNT_W'(LISTEN_TIMEOUT);
            TURN, STORE, SEEK: tmr_load_val = CNT_W'(ACT_TIMEOUT);
            COOLDOWN:          tmr_load_val = CNT_W'(COOLDOWN_CYCLES);
            default:           tmr_load_val = '0;
        endcase
    end

    assign tmr_load = (state_d != state_q);
    assign tmr_en   = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            retries_q     <= '0;
            fault_q       <= 1'b0;
            last_cmd_q    <= CMD_NONE;
            turn_start_q  <= 1'b0;
            store_start_q <= 1'b0;
            seek_start_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            retries_q     <= retries_d;
            fault_q       <= fault_d;
            last_cmd_q    <= last_cmd_d;
            turn_start_q  <= turn_start_d;
            store_start_q <= store_start_d;
            seek_start_q  <= seek_start_d;
        end
    end

    // Mics stay on while listening/decoding and throughout a sound seek.
    assign freq_enable = (state_q == LISTEN) || (state_q == DECODE) || (state_q == SEEK);
    assign busy        = (state_q != IDLE);
    assign fault       = fault_q;
    assign last_cmd    = last_cmd_q;
    assign turn_start  = turn_start_q;
    assign store_start = store_start_q;
    assign seek_start  = seek_start_q;

endmodule

`default_nettype wire

// File: tb/tb_washer_task_sequencer.sv
// ---------------------------------------------------------------------------
// tb_washer_task_sequencer : randomized episodes vs. planned timeline. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_washer_task_sequencer;

    localparam int unsigned LT = 20;
    localparam int unsigned AT = 50;
    localparam int unsigned CD = 10;
    localparam int unsigned MR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       washer_detected;
    logic       done_count;
    logic [2:0] command;
    logic       turn_done;
    logic       store_done;
    logic       seek_done;
    logic       freq_enable;
    logic       turn_start;
    logic       store_start;
    logic       seek_start;
    logic       busy;
    logic       fault;
    logic [2:0] last_cmd;

    washer_task_sequencer #(
        .LISTEN_TIMEOUT  (LT),
        .ACT_TIMEOUT     (AT),
        .COOLDOWN_CYCLES (CD),
        .MAX_RETRIES     (MR),
        .CNT_W           (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .washer_detected (washer_detected),
        .done_count      (done_count),
        .command         (command),
        .turn_done       (turn_done),
        .store_done      (store_done),
        .seek_done       (seek_done),
        .freq_enable     (freq_enable),
        .turn_start      (turn_start),
        .store_start     (store_start),
        .seek_start      (seek_start),
        .busy            (busy),
        .fault           (fault),
        .last_cmd        (last_cmd)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       washer;
        logic       done;
        logic [2:0] cmd;
        logic       td;
        logic       sd;
        logic       kd;
    } stim_t;

    typedef struct packed {
        logic       busy;
        logic       fe;
        logic [2:0] starts;
        logic       flt;
        logic [2:0] lc;
    } expv_t;

    // One entry per clock cycle: what to drive, and what the outputs must show.
    stim_t      stim_q[$];
    expv_t      exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic       m_fault  = 1'b0;
    logic [2:0] m_lc     = 3'b000;
    bit         hold_washer = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic stim_t rnd_stim();
        logic [7:0] r;
        stim_t      s;
        r = 8'($urandom);
        s = r;
        return s;
    endfunction

    task automatic push(input stim_t s, input logic b, input logic fe, input logic [2:0] st);
        expv_t e;
        if (hold_washer) s.washer = 1'b1;
        e.busy   = b;
        e.fe     = fe;
        e.starts = st;
        e.flt    = m_fault;
        e.lc     = m_lc;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic plan_gap(input int n);
        stim_t s;
        for (int i = 0; i < n; i++) begin
            s = rnd_stim();
            s.washer = 1'b0;
            push(s, 1'b0, 1'b0, 3'b000);
        end
    endtask

    // mode: 0 random, 1 all listens time out, 2 bad command then Turn180,
    //       3 Turn180 task times out, 4 StoreWasher quick, 5 GoToSound (long)
    task automatic plan_episode(input int mode);
        stim_t      s;
        int         kind, d, e, n;
        logic [2:0] c;
        bit         launched, task_to;
        s = rnd_stim();
        s.washer = 1'b1;
        push(s, 1'b0, 1'b0, 3'b000);
        m_fault  = 1'b0;
        launched = 1'b0;
        c        = 3'b000;
        for (int att = 0; att < int'(MR) && !launched; att++) begin
            kind = $urandom_range(0, 3);
            if (mode == 1)      kind = 0;
            else if (mode == 2) kind = (att == 0) ? 1 : 2;
            else if (mode >= 3) kind = 2;
            if (kind == 0) begin
                for (int i = 0; i < int'(LT); i++) begin
                    s = rnd_stim(); s.done = 1'b0;
                    push(s, 1'b1, 1'b1, 3'b000);
                end
            end else begin
                d = ($urandom_range(0, 3) == 0) ? int'(LT) - 1 : $urandom_range(0, LT - 1);
                if (mode == 4) d = 4;
                if (mode == 5) d = 3;
                for (int i = 0; i < d; i++) begin
                    s = rnd_stim(); s.done = 1'b0;
                    push(s, 1'b1, 1'b1, 3'b000);
                end
                s = rnd_stim(); s.done = 1'b1;
                push(s, 1'b1, 1'b1, 3'b000);
                if (kind == 1) begin
                    case ($urandom_range(0, 4))
                        0: c = 3'b000;
                        1: c = 3'b011;
                        2: c = 3'b101;
                        3: c = 3'b110;
                        default: c = 3'b111;
                    endcase
                    if (mode == 2) c = 3'b011;
                end else begin
                    case ($urandom_range(0, 2))
                        0: c = 3'b001;
                        1: c = 3'b010;
                        default: c = 3'b100;
                    endcase
                    if (mode == 2 || mode == 3) c = 3'b001;
                    if (mode == 4) c = 3'b010;
                    if (mode == 5) c = 3'b100;
                    launched = 1'b1;
                end
                s = rnd_stim(); s.cmd = c;
                push(s, 1'b1, 1'b1, 3'b000);
            end
            if (!launched) begin
                s = rnd_stim();
                push(s, 1'b1, 1'b0, 3'b000);
                if (att == int'(MR) - 1) m_fault = 1'b1;
            end
        end
        if (launched) begin
            m_lc    = c;
            task_to = ($urandom_range(0, 4) == 0) || (mode == 3) || (mode == 5);
            e = ($urandom_range(0, 3) == 0) ? int'(AT) - 1 : $urandom_range(0, AT - 1);
            if (mode == 4) e = 7;
            n = task_to ? int'(AT) : e + 1;
            for (int i = 0; i < n; i++) begin
                s = rnd_stim();
                if (c == 3'b001) s.td = (!task_to && i == e);
                if (c == 3'b010) s.sd = (!task_to && i == e);
                if (c == 3'b100) s.kd = (!task_to && i == e);
                push(s, 1'b1, (c == 3'b100), (i == 0) ? {c[0], c[1], c[2]} : 3'b000);
            end
            if (task_to) m_fault = 1'b1;
        end
        for (int i = 0; i < int'(CD); i++) begin
            s = rnd_stim();
            push(s, 1'b1, 1'b0, 3'b000);
        end
    endtask

    task automatic run_cycles(input int n);
        expv_t ev;
        stim_t sv;
        for (int i = 0; i < n && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
            ev = exp_q.pop_front();
            sv = stim_q.pop_front();
            check_eq("busy",     32'(busy),        32'(ev.busy));
            check_eq("freq_en",  32'(freq_enable), 32'(ev.fe));
            check_eq("starts",   32'({turn_start, store_start, seek_start}), 32'(ev.starts));
            check_eq("fault",    32'(fault),       32'(ev.flt));
            check_eq("last_cmd", 32'(last_cmd),    32'(ev.lc));
            {washer_detected, done_count, command, turn_done, store_done, seek_done} = sv;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 32'({freq_enable, turn_start, store_start, seek_start, busy, fault, last_cmd}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {washer_detected, done_count, command, turn_done, store_done, seek_done} = '0;
        #12;
        check_all_zero("reset_outs");
        @(negedge clk);
        rst_n = 1'b1;

        plan_episode(4); plan_gap(2);
        plan_episode(5); plan_gap(1);
        plan_episode(1); plan_gap(0);
        plan_episode(2); plan_gap(3);
        plan_episode(3); plan_gap(1);
        run_cycles(100000);

        for (int k = 0; k < 25; k++) begin
            plan_episode(0);
            plan_gap($urandom_range(0, 3));
        end
        run_cycles(100000);

        // Reset asserted in the fifth cycle of a sound seek.
        plan_gap(1);
        plan_episode(5);
        run_cycles(12);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        stim_q.delete();
        exp_q.delete();
        m_fault = 1'b0;
        m_lc    = 3'b000;
        {washer_detected, done_count, command, turn_done, store_done, seek_done} = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        @(negedge clk);
        rst_n = 1'b1;

        hold_washer = 1'b1;
        plan_episode(4);
        plan_episode(0);
        hold_washer = 1'b0;
        plan_gap(3);
        run_cycles(100000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
